// File: rtl/spi_seq_pkg.sv
// Shared definitions for the SPI flash read sequencer: FSM states,
// SPI master register map and command codes.
package spi_seq_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CS_ON,
        ST_TX_DATA,
        ST_TX_CMD,
        ST_TX_WAIT_HI,
        ST_TX_WAIT_LO,
        ST_RX_CMD,
        ST_RX_WAIT_HI,
        ST_RX_WAIT_LO,
        ST_RX_READ,
        ST_PUSH,
        ST_CS_OFF,
        ST_DONE
    } seq_state_t;

    // SPI master register addresses
    localparam logic [2:0] REG_DATA = 3'd0;
    localparam logic [2:0] REG_CMD  = 3'd1;
    localparam logic [2:0] REG_CS   = 3'd2;

    // Command register codes
    localparam logic [7:0] SPI_CMD_WRITE = 8'h01;
    localparam logic [7:0] SPI_CMD_READ  = 8'h02;

    // A request length of zero stands for a full 256-byte page
    function automatic logic [8:0] len_to_count(input logic [7:0] len);
        return (len == 8'd0) ? 9'd256 : {1'b0, len};
    endfunction

endpackage

// File: rtl/spi_seq_wb_if.sv
// Single-access wishbone master: latches one register access and holds
// cyc/stb/adr/dat/we stable until ack, then drops the cycle on that edge.
module spi_seq_wb_if (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    input  logic       req_we,
    input  logic [2:0] req_adr,
    input  logic [7:0] req_dat,
    output logic       ack,
    output logic [7:0] rdata,
    output logic       m_cyc,
    output logic       m_stb,
    output logic       m_we,
    output logic [2:0] m_adr,
    output logic [7:0] m_dat_w,
    input  logic [7:0] m_dat_r,
    input  logic       m_ack
);

    assign ack   = m_cyc & m_ack;
    assign rdata = m_dat_r;

    // A new request is only taken while the bus is idle, which forces one
    // idle clock between consecutive accesses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cyc   <= 1'b0;
            m_stb   <= 1'b0;
            m_we    <= 1'b0;
            m_adr   <= 3'd0;
            m_dat_w <= 8'd0;
        end else if (m_cyc) begin
            if (m_ack) begin
                m_cyc <= 1'b0;
                m_stb <= 1'b0;
            end
        end else if (req) begin
            m_cyc   <= 1'b1;
            m_stb   <= 1'b1;
            m_we    <= req_we;
            m_adr   <= req_adr;
            m_dat_w <= req_dat;
        end
    end

endmodule

// File: rtl/spi_flash_rd_seq.sv
// SPI flash read sequencer driving a wishbone SPI master register block.
// Optional TIP watchdog enabled by defining SPI_SEQ_TIMEOUT_EN.
module spi_flash_rd_seq
    import spi_seq_pkg::*;
#(
    parameter logic [7:0] CMD_OPCODE  = 8'h03,
    parameter logic [2:0] CS_SEL      = 3'd0,
    parameter int         TIMEOUT_CYC = 4096
) (
    input  logic        wb_clk_i,
    input  logic        arst_n_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [23:0] req_addr_i,
    input  logic [7:0]  req_len_i,
    output logic        m_cyc_o,
    output logic        m_stb_o,
    output logic        m_we_o,
    output logic [2:0]  m_adr_o,
    output logic [7:0]  m_dat_o,
    input  logic [7:0]  m_dat_i,
    input  logic        m_ack_i,
    input  logic        tip_i,
    output logic        dout_valid_o,
    input  logic        dout_ready_i,
    output logic [7:0]  dout_data_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    localparam logic [7:0] CS_ACTIVE = ~(8'd1 << CS_SEL);

    seq_state_t  state_q, state_d;
    logic [23:0] addr_q;
    logic [8:0]  byte_cnt;
    logic [1:0]  tx_idx;
    logic [7:0]  dout_q;
    logic [7:0]  tx_byte;
    logic        bus_req, bus_we, bus_ack;
    logic [2:0]  bus_adr;
    logic [7:0]  bus_dat, bus_rdata;
    logic        wd_expired;

    spi_seq_wb_if u_wb_if (
        .clk     (wb_clk_i),
        .rst_n   (arst_n_i),
        .req     (bus_req),
        .req_we  (bus_we),
        .req_adr (bus_adr),
        .req_dat (bus_dat),
        .ack     (bus_ack),
        .rdata   (bus_rdata),
        .m_cyc   (m_cyc_o),
        .m_stb   (m_stb_o),
        .m_we    (m_we_o),
        .m_adr   (m_adr_o),
        .m_dat_w (m_dat_o),
        .m_dat_r (m_dat_i),
        .m_ack   (m_ack_i)
    );

    always_comb begin
        case (tx_idx)
            2'd0:    tx_byte = CMD_OPCODE;
            2'd1:    tx_byte = addr_q[23:16];
            2'd2:    tx_byte = addr_q[15:8];
            default: tx_byte = addr_q[7:0];
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge arst_n_i) begin
        if (!arst_n_i) state_q <= ST_IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        bus_req = 1'b0;
        bus_we  = 1'b1;
        bus_adr = REG_DATA;
        bus_dat = 8'h00;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) state_d = ST_CS_ON;
            end
            ST_CS_ON: begin
                bus_req = 1'b1;
                bus_adr = REG_CS;
                bus_dat = CS_ACTIVE;
                if (bus_ack) state_d = ST_TX_DATA;
            end
            ST_TX_DATA: begin
                bus_req = 1'b1;
                bus_dat = tx_byte;
                if (bus_ack) state_d = ST_TX_CMD;
            end
            ST_TX_CMD: begin
                bus_req = 1'b1;
                bus_adr = REG_CMD;
                bus_dat = SPI_CMD_WRITE;
                if (bus_ack) state_d = ST_TX_WAIT_HI;
            end
            ST_TX_WAIT_HI: begin
                if (tip_i) state_d = ST_TX_WAIT_LO;
            end
            ST_TX_WAIT_LO: begin
                if (!tip_i) state_d = (tx_idx == 2'd3) ? ST_RX_CMD : ST_TX_DATA;
            end
            ST_RX_CMD: begin
                bus_req = 1'b1;
                bus_adr = REG_CMD;
                bus_dat = SPI_CMD_READ;
                if (bus_ack) state_d = ST_RX_WAIT_HI;
            end
            ST_RX_WAIT_HI: begin
                if (tip_i) state_d = ST_RX_WAIT_LO;
            end
            ST_RX_WAIT_LO: begin
                if (!tip_i) state_d = ST_RX_READ;
            end
            ST_RX_READ: begin
                bus_req = 1'b1;
                bus_we  = 1'b0;
                if (bus_ack) state_d = ST_PUSH;
            end
            ST_PUSH: begin
                if (dout_ready_i) state_d = (byte_cnt == 9'd1) ? ST_CS_OFF : ST_RX_CMD;
            end
            ST_CS_OFF: begin
                bus_req = 1'b1;
                bus_adr = REG_CS;
                bus_dat = 8'hFF;
                if (bus_ack) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (wd_expired) state_d = ST_CS_OFF;
    end

    // Request capture, transmit byte index, remaining-byte count and read data
    always_ff @(posedge wb_clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            addr_q   <= 24'd0;
            byte_cnt <= 9'd0;
            tx_idx   <= 2'd0;
            dout_q   <= 8'd0;
        end else begin
            if (state_q == ST_IDLE && req_valid_i) begin
                addr_q   <= req_addr_i;
                byte_cnt <= len_to_count(req_len_i);
                tx_idx   <= 2'd0;
            end
            if (state_q == ST_TX_WAIT_LO && !tip_i && !wd_expired)
                tx_idx <= tx_idx + 2'd1;
            if (state_q == ST_RX_READ && bus_ack)
                dout_q <= bus_rdata;
            if (state_q == ST_PUSH && dout_ready_i)
                byte_cnt <= byte_cnt - 9'd1;
        end
    end

    assign req_ready_o  = (state_q == ST_IDLE);
    assign busy_o       = (state_q != ST_IDLE);
    assign dout_valid_o = (state_q == ST_PUSH);
    assign dout_data_o  = dout_q;

`ifdef SPI_SEQ_TIMEOUT_EN
    localparam int WD_W = ($clog2(TIMEOUT_CYC) > 12) ? $clog2(TIMEOUT_CYC) : 12;

    logic [WD_W-1:0] wd_cnt;
    logic            in_wait;
    logic            aborted_q;

    assign in_wait = (state_q == ST_TX_WAIT_HI) || (state_q == ST_TX_WAIT_LO) ||
                     (state_q == ST_RX_WAIT_HI) || (state_q == ST_RX_WAIT_LO);
    assign wd_expired = in_wait && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

    // Watchdog restarts on every state change; an abort is remembered until IDLE
    always_ff @(posedge wb_clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            wd_cnt    <= '0;
            aborted_q <= 1'b0;
        end else begin
            if (state_d != state_q || !in_wait) wd_cnt <= '0;
            else                                wd_cnt <= wd_cnt + WD_W'(1);
            if (wd_expired)               aborted_q <= 1'b1;
            else if (state_q == ST_IDLE)  aborted_q <= 1'b0;
        end
    end

    assign done_o = (state_q == ST_DONE) && !aborted_q;
    assign err_o  = (state_q == ST_DONE) && aborted_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYC != 0);
    assign wd_expired     = 1'b0;
    assign done_o         = (state_q == ST_DONE);
    assign err_o          = 1'b0;
`endif

endmodule

// File: tb/tb_spi_flash_rd_seq.sv
// Directed self-checking bench for spi_flash_rd_seq with a wishbone/TIP
// responder model; the timeout scenario runs when SPI_SEQ_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_spi_flash_rd_seq;
    import spi_seq_pkg::*;

    logic        wb_clk_i = 1'b0;
    logic        arst_n_i = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [23:0] req_addr_i = 24'd0;
    logic [7:0]  req_len_i = 8'd0;
    logic        m_cyc_o, m_stb_o, m_we_o;
    logic [2:0]  m_adr_o;
    logic [7:0]  m_dat_o, m_dat_i;
    logic        m_ack_i, tip_i;
    logic        dout_valid_o;
    logic        dout_ready_i = 1'b1;
    logic [7:0]  dout_data_o;
    logic        busy_o, done_o, err_o;

    int checks = 0;
    int errors = 0;

    logic        ack_r, tip_r, clr;
    int          wait_cnt, tip_cnt, rd_count, ack_delay;
    bit          tip_stuck;
    logic [10:0] wlog[$];
    logic [7:0]  dlog[$];
    int          done_cnt, err_cnt;
    bit          unstable, bus_err;
    logic        cyc_p, ack_p, we_p;
    logic [2:0]  adr_p;
    logic [7:0]  dat_p;

    spi_flash_rd_seq #(.CMD_OPCODE(8'h03), .CS_SEL(3'd0), .TIMEOUT_CYC(16)) dut (
        .wb_clk_i    (wb_clk_i),
        .arst_n_i    (arst_n_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_addr_i  (req_addr_i),
        .req_len_i   (req_len_i),
        .m_cyc_o     (m_cyc_o),
        .m_stb_o     (m_stb_o),
        .m_we_o      (m_we_o),
        .m_adr_o     (m_adr_o),
        .m_dat_o     (m_dat_o),
        .m_dat_i     (m_dat_i),
        .m_ack_i     (m_ack_i),
        .tip_i       (tip_i),
        .dout_valid_o(dout_valid_o),
        .dout_ready_i(dout_ready_i),
        .dout_data_o (dout_data_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    assign m_ack_i = ack_r;
    assign tip_i   = tip_r;
    assign m_dat_i = 8'(32'hA0 + rd_count);

    // Wishbone slave with programmable ack latency; a command write starts an 8-clock TIP pulse
    always @(posedge wb_clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            ack_r    <= 1'b0;
            wait_cnt <= 0;
            tip_cnt  <= 0;
            tip_r    <= 1'b0;
        end else begin
            ack_r <= 1'b0;
            if (tip_cnt != 0) begin
                tip_r   <= 1'b1;
                tip_cnt <= tip_cnt - 1;
            end else begin
                tip_r <= 1'b0;
            end
            if (m_cyc_o && m_stb_o && !ack_r) begin
                if (wait_cnt >= ack_delay) begin
                    ack_r    <= 1'b1;
                    wait_cnt <= 0;
                    if (m_we_o) begin
                        wlog.push_back({m_adr_o, m_dat_o});
                        if (m_adr_o == REG_CMD && !tip_stuck) tip_cnt <= 8;
                    end
                end else begin
                    wait_cnt <= wait_cnt + 1;
                end
            end
        end
    end

    // Bus/stream monitor: read data source, pulse counts, stream log, bus-stability flags
    always @(posedge wb_clk_i) begin
        if (clr) begin
            rd_count <= 0;
            done_cnt <= 0;
            err_cnt  <= 0;
            unstable <= 1'b0;
            bus_err  <= 1'b0;
        end else begin
            if (m_ack_i && m_cyc_o && !m_we_o) rd_count <= rd_count + 1;
            if (done_o) done_cnt <= done_cnt + 1;
            if (err_o) err_cnt <= err_cnt + 1;
            if (dout_valid_o && dout_ready_i) dlog.push_back(dout_data_o);
            if (m_cyc_o && cyc_p && (m_adr_o != adr_p || m_dat_o != dat_p ||
                m_we_o != we_p || !m_stb_o)) unstable <= 1'b1;
            if (cyc_p && ack_p && m_cyc_o) bus_err <= 1'b1;
        end
        cyc_p <= m_cyc_o;
        ack_p <= m_ack_i;
        adr_p <= m_adr_o;
        dat_p <= m_dat_o;
        we_p  <= m_we_o;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [23:0] addr, input logic [7:0] len);
        @(negedge wb_clk_i);
        req_valid_i = 1'b1;
        req_addr_i  = addr;
        req_len_i   = len;
        @(negedge wb_clk_i);
        req_valid_i = 1'b0;
    endtask

    task automatic clearLogs();
        @(negedge wb_clk_i);
        clr = 1'b1;
        wlog.delete();
        dlog.delete();
        @(negedge wb_clk_i);
        clr = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int limit);
        int n;
        n = 0;
        while ((done_cnt + err_cnt) == 0 && n < limit) begin
            @(negedge wb_clk_i);
            n++;
        end
        checkOutput(tag, 32'((done_cnt + err_cnt) != 0), 32'd1);
        repeat (4) @(negedge wb_clk_i);
    endtask

    task automatic waitValid(input string tag, input int limit);
        int n;
        n = 0;
        while (!dout_valid_o && n < limit) begin
            @(negedge wb_clk_i);
            n++;
        end
        checkOutput(tag, 32'(dout_valid_o), 32'd1);
    endtask

    function automatic logic [10:0] wlogAt(input int i);
        return (i < wlog.size()) ? wlog[i] : 11'h7FF;
    endfunction

    // Expected register write trace for a 4-byte read from address 0x123456
    task automatic checkTrace4(input string tag);
        logic [10:0] exp_w[14];
        exp_w = '{ {REG_CS, 8'hFE},
                   {REG_DATA, 8'h03}, {REG_CMD, 8'h01},
                   {REG_DATA, 8'h12}, {REG_CMD, 8'h01},
                   {REG_DATA, 8'h34}, {REG_CMD, 8'h01},
                   {REG_DATA, 8'h56}, {REG_CMD, 8'h01},
                   {REG_CMD, 8'h02}, {REG_CMD, 8'h02},
                   {REG_CMD, 8'h02}, {REG_CMD, 8'h02},
                   {REG_CS, 8'hFF} };
        checkOutput({tag, "_wcount"}, 32'(wlog.size()), 32'd14);
        for (int i = 0; i < 14; i++)
            checkOutput($sformatf("%s_w%0d", tag, i), 32'(wlogAt(i)), 32'(exp_w[i]));
        checkOutput({tag, "_dcount"}, 32'(dlog.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            checkOutput($sformatf("%s_d%0d", tag, i),
                        32'((i < dlog.size()) ? dlog[i] : 8'h00), 32'hA0 + 32'(i));
        checkOutput({tag, "_done"}, 32'(done_cnt), 32'd1);
        checkOutput({tag, "_err"}, 32'(err_cnt), 32'd0);
        checkOutput({tag, "_stable"}, 32'(unstable), 32'd0);
        checkOutput({tag, "_idlegap"}, 32'(bus_err), 32'd0);
    endtask

    initial begin
        int  wsz, n;
        bit  stall_bad;
        clr       = 1'b0;
        ack_delay = 0;
        tip_stuck = 1'b0;

        // Reset values, sampled while reset is held
        repeat (3) @(negedge wb_clk_i);
        #1;
        checkOutput("rst_ready", 32'(req_ready_o), 32'd1);
        checkOutput("rst_busy", 32'(busy_o), 32'd0);
        checkOutput("rst_cyc", 32'(m_cyc_o), 32'd0);
        checkOutput("rst_stb", 32'(m_stb_o), 32'd0);
        checkOutput("rst_valid", 32'(dout_valid_o), 32'd0);
        checkOutput("rst_done", 32'(done_o), 32'd0);
        checkOutput("rst_err", 32'(err_o), 32'd0);
        checkOutput("rst_data", 32'(dout_data_o), 32'd0);
        arst_n_i = 1'b1;
        clearLogs();

        $display("[TB] basic 4-byte read, immediate ack");
        applyStimulus(24'h123456, 8'd4);
        checkOutput("accept_busy", 32'(busy_o), 32'd1);
        checkOutput("accept_ready", 32'(req_ready_o), 32'd0);
        waitDone("basic_complete", 2000);
        checkTrace4("basic");
        checkOutput("basic_idle", 32'(req_ready_o), 32'd1);

        $display("[TB] 4-byte read, ack delayed 3 clocks");
        clearLogs();
        ack_delay = 3;
        applyStimulus(24'h123456, 8'd4);
        waitDone("slow_complete", 3000);
        checkTrace4("slow");
        ack_delay = 0;

        $display("[TB] backpressure on second byte");
        clearLogs();
        dout_ready_i = 1'b0;
        applyStimulus(24'h123456, 8'd4);
        waitValid("bp_first_valid", 500);
        checkOutput("bp_first_data", 32'(dout_data_o), 32'hA0);
        dout_ready_i = 1'b1;
        @(negedge wb_clk_i);
        dout_ready_i = 1'b0;
        waitValid("bp_second_valid", 500);
        wsz = wlog.size();
        stall_bad = 1'b0;
        repeat (50) begin
            @(negedge wb_clk_i);
            if (!dout_valid_o || dout_data_o !== 8'hA1 || m_cyc_o) stall_bad = 1'b1;
        end
        checkOutput("bp_hold", 32'(stall_bad), 32'd0);
        checkOutput("bp_nobus", 32'(wlog.size()), 32'(wsz));
        checkOutput("bp_nodone", 32'(done_cnt), 32'd0);
        dout_ready_i = 1'b1;
        waitDone("bp_complete", 2000);
        checkTrace4("bp");

        $display("[TB] length 0 means 256 bytes");
        clearLogs();
        applyStimulus(24'hABCDEF, 8'd0);
        waitDone("len0_complete", 20000);
        checkOutput("len0_dcount", 32'(dlog.size()), 32'd256);
        checkOutput("len0_first", 32'((dlog.size() > 0) ? dlog[0] : 8'h00), 32'hA0);
        checkOutput("len0_last", 32'((dlog.size() > 255) ? dlog[255] : 8'h00), 32'h9F);
        checkOutput("len0_wcount", 32'(wlog.size()), 32'd266);
        checkOutput("len0_addr", 32'(wlogAt(3)), 32'({REG_DATA, 8'hAB}));
        checkOutput("len0_csoff", 32'(wlogAt(265)), 32'({REG_CS, 8'hFF}));
        checkOutput("len0_done", 32'(done_cnt), 32'd1);

        $display("[TB] reset during receive wait");
        clearLogs();
        applyStimulus(24'h123456, 8'd4);
        n = 0;
        while (!(wlog.size() >= 10 && tip_i) && n < 1000) begin
            @(negedge wb_clk_i);
            n++;
        end
        checkOutput("rstmid_reached", 32'(wlog.size() >= 10 && tip_i), 32'd1);
        arst_n_i = 1'b0;
        #1;
        checkOutput("rstmid_cyc", 32'(m_cyc_o), 32'd0);
        checkOutput("rstmid_ready", 32'(req_ready_o), 32'd1);
        checkOutput("rstmid_busy", 32'(busy_o), 32'd0);
        @(posedge wb_clk_i);
        #1;
        checkOutput("rstmid_clk_ready", 32'(req_ready_o), 32'd1);
        @(negedge wb_clk_i);
        arst_n_i = 1'b1;
        repeat (30) @(negedge wb_clk_i);
        checkOutput("rstmid_nocsoff", 32'(wlog.size()), 32'd10);
        checkOutput("rstmid_nodone", 32'(done_cnt), 32'd0);
        checkOutput("rstmid_idle", 32'(req_ready_o), 32'd1);

`ifdef SPI_SEQ_TIMEOUT_EN
        $display("[TB] TIP stuck low, watchdog abort");
        clearLogs();
        tip_stuck = 1'b1;
        applyStimulus(24'h123456, 8'd4);
        waitDone("to_complete", 500);
        checkOutput("to_wcount", 32'(wlog.size()), 32'd4);
        checkOutput("to_w0", 32'(wlogAt(0)), 32'({REG_CS, 8'hFE}));
        checkOutput("to_w1", 32'(wlogAt(1)), 32'({REG_DATA, 8'h03}));
        checkOutput("to_w2", 32'(wlogAt(2)), 32'({REG_CMD, 8'h01}));
        checkOutput("to_w3", 32'(wlogAt(3)), 32'({REG_CS, 8'hFF}));
        checkOutput("to_err", 32'(err_cnt), 32'd1);
        checkOutput("to_done", 32'(done_cnt), 32'd0);
        checkOutput("to_idle", 32'(req_ready_o), 32'd1);
        tip_stuck = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
